// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard unit for the 5-stage pipeline.
// Carries the E-stage write tags through M and W, then compares them with the
// D- and E-stage source registers. From that it drives the stall, the E bubble
// and the forwarding selects. It also tracks how long the multi-cycle
// mult/div unit stays busy.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic [1:0] tuse1D,
  input  logic [1:0] tuse2D,
  input  logic       md_use_D,
  input  logic [4:0] ra1E,
  input  logic [4:0] ra2E,
  input  logic [4:0] waE,
  input  logic [1:0] resE,
  input  logic       start_E,
  output logic       stall,
  output logic       Eclr,
  output logic [1:0] fwd1D,
  output logic [1:0] fwd2D,
  output logic [1:0] fwd1E,
  output logic [1:0] fwd2E,
  output logic       fwd2M,
  output logic       md_busy
);

  localparam logic [1:0] RES_NW  = 2'd0;
  localparam logic [1:0] RES_ALU = 2'd1;
  localparam logic [1:0] RES_DM  = 2'd2;
  localparam logic [1:0] RES_PC  = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [3:0] MD_LOAD = 4'(MD_LAT);

  logic [4:0] wa_m, ra2_m, wa_w;
  logic [1:0] res_m, res_w;
  logic [3:0] md_cnt;

  logic       live_e, live_m, live_w;
  logic       src_e, src_m;
  logic [1:0] tnew_e, tnew_m;
  logic       stall_rs, stall_rt, stall_md;

  // Cycles until the producer's result exists, by stage and result class.
  function automatic logic [1:0] calc_tnew_e(input logic [1:0] res);
    case (res)
      RES_ALU: calc_tnew_e = 2'd1;
      RES_DM:  calc_tnew_e = 2'd2;
      default: calc_tnew_e = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] calc_tnew_m(input logic [1:0] res);
    calc_tnew_m = (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // A source stalls when its producer in E or M is too late for its Tuse.
  function automatic logic src_stall(input logic [4:0] ra, input logic [1:0] tuse,
                                     input logic [4:0] we, input logic le,
                                     input logic [1:0] te, input logic [4:0] wm,
                                     input logic lm, input logic [1:0] tm);
    src_stall = (ra != 5'd0) && (tuse != TUSE_NONE) &&
                ((le && (ra == we) && (tuse < te)) ||
                 (lm && (ra == wm) && (tuse < tm)));
  endfunction

  // The nearest stage that already holds the value wins: E, then M, then W.
  function automatic logic [1:0] sel_d(input logic [4:0] ra,
                                       input logic [4:0] we, input logic se,
                                       input logic [4:0] wm, input logic sm,
                                       input logic [4:0] ww, input logic sw);
    if (se && (ra == we))      sel_d = 2'd1;
    else if (sm && (ra == wm)) sel_d = 2'd2;
    else if (sw && (ra == ww)) sel_d = 2'd3;
    else                       sel_d = 2'd0;
  endfunction

  // Write tags advance one stage per clock; a stalled E receives a bubble upstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_m  <= 5'd0;
      res_m <= RES_NW;
      ra2_m <= 5'd0;
      wa_w  <= 5'd0;
      res_w <= RES_NW;
    end else begin
      wa_m  <= waE;
      res_m <= resE;
      ra2_m <= ra2E;
      wa_w  <= wa_m;
      res_w <= res_m;
    end
  end

  // Mult/div busy counter; a new start reloads it even while it is still counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt <= 4'd0;
    end else if (start_E) begin
      md_cnt <= MD_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Stage liveness, Tnew and hazard detection.
  always_comb begin
    live_e   = (waE  != 5'd0) && (resE  != RES_NW);
    live_m   = (wa_m != 5'd0) && (res_m != RES_NW);
    live_w   = (wa_w != 5'd0) && (res_w != RES_NW);
    src_e    = live_e && (resE == RES_PC);
    src_m    = live_m && ((res_m == RES_ALU) || (res_m == RES_PC));
    tnew_e   = calc_tnew_e(resE);
    tnew_m   = calc_tnew_m(res_m);
    stall_rs = src_stall(ra1D, tuse1D, waE, live_e, tnew_e, wa_m, live_m, tnew_m);
    stall_rt = src_stall(ra2D, tuse2D, waE, live_e, tnew_e, wa_m, live_m, tnew_m);
    stall_md = md_use_D && md_busy;
  end

  // Busy covers the start cycle itself as well as the counted cycles after it.
  always_comb begin
    md_busy = start_E || (md_cnt != 4'd0);
  end

  // Stall and forward outputs; reset forces them quiet without waiting for a clock.
  always_comb begin
    stall = 1'b0;
    fwd1D = 2'd0;
    fwd2D = 2'd0;
    fwd1E = 2'd0;
    fwd2E = 2'd0;
    fwd2M = 1'b0;
    if (!rst) begin
      stall = stall_rs || stall_rt || stall_md;
      fwd1D = sel_d(ra1D, waE, src_e, wa_m, src_m, wa_w, live_w);
      fwd2D = sel_d(ra2D, waE, src_e, wa_m, src_m, wa_w, live_w);
      fwd1E = sel_d(ra1E, 5'd0, 1'b0, wa_m, src_m, wa_w, live_w);
      fwd2E = sel_d(ra2E, 5'd0, 1'b0, wa_m, src_m, wa_w, live_w);
      fwd2M = (ra2_m != 5'd0) && (ra2_m == wa_w) && (res_w != RES_NW);
    end
    Eclr = stall;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
// Each step drives one cycle of D/E inputs, pushes the expected outputs, and
// pops and compares them at the following negedge.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ra1D, ra2D, ra1E, ra2E, waE;
  logic [1:0] tuse1D, tuse2D, resE;
  logic       md_use_D, start_E;
  logic       stall, Eclr, fwd2M, md_busy;
  logic [1:0] fwd1D, fwd2D, fwd1E, fwd2E;

  typedef struct {
    string      tag;
    logic       stall;
    logic [1:0] f1d;
    logic [1:0] f2d;
    logic [1:0] f1e;
    logic [1:0] f2e;
    logic       f2m;
    logic       busy;
  } exp_t;

  exp_t expQ[$];
  int   nAsserts = 0;
  int   nFails   = 0;

  hazard_ctrl #(.MD_LAT(5)) dut (
    .clk(clk), .rst(rst),
    .ra1D(ra1D), .ra2D(ra2D), .tuse1D(tuse1D), .tuse2D(tuse2D), .md_use_D(md_use_D),
    .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE), .start_E(start_E),
    .stall(stall), .Eclr(Eclr), .fwd1D(fwd1D), .fwd2D(fwd2D),
    .fwd1E(fwd1E), .fwd2E(fwd2E), .fwd2M(fwd2M), .md_busy(md_busy)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input string field,
                     input logic [1:0] obs, input logic [1:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic applyStimulus(input string tag,
      input logic [4:0] iRa1D, input logic [4:0] iRa2D,
      input logic [1:0] iTu1, input logic [1:0] iTu2, input logic iMdu,
      input logic [4:0] iRa1E, input logic [4:0] iRa2E,
      input logic [4:0] iWaE, input logic [1:0] iResE, input logic iStart,
      input logic eStall, input logic [1:0] eF1D, input logic [1:0] eF2D,
      input logic [1:0] eF1E, input logic [1:0] eF2E, input logic eF2M,
      input logic eBusy);
    exp_t e;
    ra1D = iRa1D; ra2D = iRa2D; tuse1D = iTu1; tuse2D = iTu2; md_use_D = iMdu;
    ra1E = iRa1E; ra2E = iRa2E; waE = iWaE; resE = iResE; start_E = iStart;
    e.tag = tag; e.stall = eStall; e.f1d = eF1D; e.f2d = eF2D;
    e.f1e = eF1E; e.f2e = eF2E; e.f2m = eF2M; e.busy = eBusy;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    nAsserts++;
    assert (expQ.size() != 0) else begin
      nFails++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = expQ.pop_front();
    cmp(e.tag, "stall",   {1'b0, stall},   {1'b0, e.stall});
    cmp(e.tag, "Eclr",    {1'b0, Eclr},    {1'b0, e.stall});
    cmp(e.tag, "fwd1D",   fwd1D,           e.f1d);
    cmp(e.tag, "fwd2D",   fwd2D,           e.f2d);
    cmp(e.tag, "fwd1E",   fwd1E,           e.f1e);
    cmp(e.tag, "fwd2E",   fwd2E,           e.f2e);
    cmp(e.tag, "fwd2M",   {1'b0, fwd2M},   {1'b0, e.f2m});
    cmp(e.tag, "md_busy", {1'b0, md_busy}, {1'b0, e.busy});
  endtask

  // One clocked step: drive just after posedge, compare at the negedge.
  task automatic step(input string tag,
      input logic [4:0] iRa1D, input logic [4:0] iRa2D,
      input logic [1:0] iTu1, input logic [1:0] iTu2, input logic iMdu,
      input logic [4:0] iRa1E, input logic [4:0] iRa2E,
      input logic [4:0] iWaE, input logic [1:0] iResE, input logic iStart,
      input logic eStall, input logic [1:0] eF1D, input logic [1:0] eF2D,
      input logic [1:0] eF1E, input logic [1:0] eF2E, input logic eF2M,
      input logic eBusy);
    @(posedge clk);
    #1;
    applyStimulus(tag, iRa1D, iRa2D, iTu1, iTu2, iMdu, iRa1E, iRa2E, iWaE, iResE, iStart,
                  eStall, eF1D, eF2D, eF1E, eF2E, eF2M, eBusy);
    @(negedge clk);
    checkOutput();
  endtask

  // Directed sequence: load-use, ALU-to-branch, link forwarding, $0/unused,
  // mult/div busy window and reload, then an asynchronous reset mid-stall.
  initial begin
    rst = 1'b1;
    #2;
    applyStimulus("reset", 0,0,3,3,0, 0,0,0,0,0, 0,0,0,0,0,0,0);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    step("loaduse_stall",   8,0,1,3,0,  0,0,8,2,0,   1,0,0,0,0,0,0);
    step("loaduse_release", 8,0,1,3,0,  0,0,0,0,0,   0,0,0,0,0,0,0);
    step("loaduse_fwdE_W",  0,0,3,3,0,  8,0,9,1,0,   0,0,0,3,0,0,0);
    step("alu_br_stall",    0,5,3,0,0,  0,0,5,1,0,   1,0,0,0,0,0,0);
    step("alu_br_fwdM",     0,5,3,0,0,  0,0,0,0,0,   0,0,2,0,0,0,0);
    step("link_fwdE",       31,0,0,3,0, 0,0,31,3,0,  0,1,0,0,0,0,0);
    step("link_prep",       0,0,3,3,0,  0,0,31,1,0,  0,0,0,0,0,0,0);
    step("fwdE_from_M",     0,0,3,3,0,  31,31,31,1,0, 0,0,0,2,2,0,0);
    step("link_priority",   31,0,0,3,0, 0,0,31,3,0,  0,1,0,0,0,1,0);
    step("fwdE_M_over_W",   0,0,3,3,0,  31,0,0,0,0,  0,0,0,2,0,0,0);
    step("zero_dest",       0,0,1,3,0,  0,0,0,2,0,   0,0,0,0,0,0,0);
    step("unused_tuse",     8,0,3,3,0,  0,0,8,2,0,   0,0,0,0,0,0,0);
    step("dm_in_M_stall",   8,0,0,3,0,  0,0,0,0,0,   1,0,0,0,0,0,0);
    step("dm_in_W_fwd",     8,0,0,3,0,  0,0,0,0,0,   0,3,0,0,0,0,0);

    step("md_start",        0,0,3,3,1,  0,0,0,0,1,   1,0,0,0,0,0,1);
    for (int i = 0; i < 5; i++)
      step($sformatf("md_wait_%0d", i), 0,0,3,3,1, 0,0,0,0,0, 1,0,0,0,0,0,1);
    step("md_release",      0,0,3,3,1,  0,0,0,0,0,   0,0,0,0,0,0,0);

    step("md_start_b",      0,0,3,3,0,  0,0,0,0,1,   0,0,0,0,0,0,1);
    step("md_count_b",      0,0,3,3,0,  0,0,0,0,0,   0,0,0,0,0,0,1);
    step("md_reload",       0,0,3,3,0,  0,0,0,0,1,   0,0,0,0,0,0,1);
    for (int i = 0; i < 5; i++)
      step($sformatf("md_reload_wait_%0d", i), 0,0,3,3,0, 0,0,0,0,0, 0,0,0,0,0,0,1);
    step("md_reload_done",  0,0,3,3,0,  0,0,0,0,0,   0,0,0,0,0,0,0);

    step("rst_setup",       8,0,1,3,0,  0,0,8,2,1,   1,0,0,0,0,0,1);
    step("rst_before",      8,7,1,0,1,  0,0,7,3,0,   1,0,1,0,0,0,1);
    #2;
    rst = 1'b1;
    applyStimulus("rst_async",  8,7,1,0,1, 0,0,7,3,0, 0,0,0,0,0,0,0);
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus("rst_held",   0,0,3,3,0, 0,0,0,0,0, 0,0,0,0,0,0,0);
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
    #1;
    applyStimulus("rst_release", 8,7,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0);
    #1;
    checkOutput();
    step("tags_empty",      8,7,0,0,0,  8,7,0,0,0,   0,0,0,0,0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard unit for the 5-stage pipeline; sits directly downstream of the E-stage tag register and consumes its ra1E/ra2E/waE/resE outputs.
- Carries the write tags on through M and W, compares them against D-stage source registers and their Tuse, and drives D/E stall, the Eclr bubble, and forwarding selects for D, E and M.
- Also tracks the multi-cycle mult/div unit with a busy counter.

Parameters:
MD_LAT, 5, cycles the mult/div unit stays busy after a start leaves E (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ra1D  in  5  D-stage rs index
ra2D  in  5  D-stage rt index
tuse1D  in  2  cycles until rs is needed: 0 = in D, 1 = in E, 2 = in M, 3 = unused
tuse2D  in  2  same encoding, for rt
md_use_D  in  1  D instruction reads or writes the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo)
ra1E  in  5  E-stage rs index
ra2E  in  5  E-stage rt index
waE  in  5  E-stage destination
resE  in  2  E result class: 0 = NW (no write), 1 = ALU, 2 = DM (load), 3 = PC (link)
start_E  in  1  E instruction starts mult/div
stall  out  1  freeze PC and the D register
Eclr  out  1  clear the E-stage register (bubble)
fwd1D  out  2  rs forward select in D: 0 = RF, 1 = E, 2 = M, 3 = W
fwd2D  out  2  rt forward select in D, same encoding
fwd1E  out  2  rs forward select in E: 0 = register value, 2 = M, 3 = W
fwd2E  out  2  rt forward select in E, same encoding
fwd2M  out  1  M store-data select: 0 = register value, 1 = W
md_busy  out  1  mult/div busy (debug/observe)

Behaviour:
Internal registers (async reset to 0):
- waM, resM, ra2M: load waE, resE, ra2E every posedge.
- waW, resW: load waM, resM every posedge.
- md_cnt, 4 bits.

Tnew per stage:
- E: ALU = 1, DM = 2, PC = 0.
- M: ALU = 0, DM = 1, PC = 0.
- W: 0.
- Class NW, or destination 0, never hazards and never forwards.

Stall (combinational):
- Stall on rs if ra1D != 0, tuse1D != 3, and:
  - ra1D == waE and tuse1D < TnewE, or
  - ra1D == waM and tuse1D < TnewM.
- rt rule is identical, using ra2D and tuse2D.
- md stall: md_use_D and md_busy.
- stall = OR of all three; Eclr = stall. Eclr does not depend on rst.

md_busy and md_cnt:
- md_busy = start_E or (md_cnt != 0).
- Posedge: if start_E, md_cnt <= MD_LAT; else if md_cnt != 0, decrement; else hold.
- A start_E while md_cnt != 0 reloads to MD_LAT.

Forwarding (combinational):
- A stage is a valid source only if its destination matches, is nonzero, its class != NW, and its Tnew == 0 (E: PC class only; M: ALU or PC).
- Priority is nearest first: E > M > W. Otherwise select 0.
- A stalled D instruction may still drive fwd selects; they are don't-care while stall = 1.
- E selects use M, then W, against ra1E/ra2E.
- fwd2M = 1 iff ra2M == waW, ra2M != 0, and resW != NW.

Reset:
- All tags, md_cnt and outputs go to 0 immediately: stall = 0, fwd* = 0, md_busy = 0 (given start_E = 0).
- Reset mid-stall drops stall asynchronously; the tags restart empty.

Latency: stall, forward and Eclr are same-cycle combinational; tags advance one stage per clock regardless of stall (E receives the bubble).

Test Plan:
- Load-use: resE = 2, waE = 8; D has ra1D = 8, tuse1D = 1 -> stall = Eclr = 1 for 1 cycle; next cycle waM = 8, resM = 2, tuse 1 < 1 false -> stall = 0; following cycle fwd1E = 3 (W).
- ALU to branch: resE = 1, waE = 5, ra2D = 5, tuse2D = 0 -> stall 1 cycle; then M holds ALU -> fwd2D = 2.
- Link forward: resE = 3, waE = 31, ra1D = 31, tuse1D = 0 -> stall = 0, fwd1D = 1; priority check with waM = waW = 31 also ALU still gives fwd1D = 1.
- $0 and unused: waE = 0 with resE = 2, ra1D = 0 -> no stall, fwd = 0; ra1D = 8 matches with tuse1D = 3 -> no stall.
- Mult/div, MD_LAT = 5: start_E pulse, then md_use_D = 1 -> stall exactly 6 cycles (start cycle + 5), releases when md_cnt reaches 0.
- Async reset while stall = 1 mid-sequence -> stall, fwd*, md_busy = 0 without a clock edge; waM/waW = 0 after release.
